hs_rr_arbiter: RTL
==================

Name: hs_rr_arbiter

Overview:
- N-to-1 valid/ready arbiter that shares one downstream handshake sink (typically an hs_fifo write port) between several requesters.
- Arbitration is round-robin with an optional burst lock, so one requester can move up to MAX_BURST consecutive beats before the grant rotates.
- Output is a single registered stage: 1-cycle latency, full throughput, with a requester-ID tag alongside the data.

Parameters:
- WIDTH, 1, payload width in bits.
- N, 2, number of requesters (N >= 2).
- MAX_BURST, 1, max consecutive beats per grant (>= 1); 1 = pure round-robin.
- IdBits (localparam), max(1, $clog2(N)), requester-ID width.
- CntBits (localparam), max(1, $clog2(MAX_BURST + 1)), burst counter width.

Ports:
- clk_core  input  1  core clock; the only clock.
- rst_core  input  1  reset; one clock; reset is synchronous and active-high.
- flush  input  1  synchronous clear of output stage and arbitration state.
- valid_i  input  N  per-requester valid.
- ready_o  output  N  per-requester ready; one-hot or zero.
- in  input  N x WIDTH  per-requester payload; in[i] belongs to requester i.
- ready_i  input  1  downstream ready.
- valid_o  output  1  downstream valid (registered).
- out  output  WIDTH  downstream payload (registered).
- out_id  output  IdBits  index of the requester that supplied out (registered).

Behaviour:

Reset (rst_core high at a clock edge):
- valid_o=0, out='0, out_id='0.
- State=IDLE, burst_cnt=0, owner=0, last_grant=N-1, so requester 0 wins the first arbitration.

Stall and advance:
- out_stall = valid_o & ~ready_i.
- While out_stall: output registers hold, all ready_o=0, no state changes.
- When ~out_stall, the stage advances every cycle.

Grant selection (combinational, only when ~out_stall):
- LOCKED and valid_i[owner]=1: grant = owner.
- Otherwise: grant = first i with valid_i[i]=1, searching cyclically from last_grant+1 to last_grant+N.
- No valid_i set: no grant.
- ready_o[grant]=1; all other ready_o bits are 0.
- ready_o never depends on valid_o of other requesters beyond the grant selection above.

Transfer (grant exists and ~out_stall):
- Next edge: out<=in[grant], out_id<=grant, valid_o<=1.
- Requester handshake completes in that cycle (valid_i & ready_o).

No transfer and ~out_stall:
- valid_o<=0; out and out_id hold.

State machine (IDLE, LOCKED), updated only on transfer cycles unless noted:
- IDLE, transfer, MAX_BURST>1: go LOCKED, owner<=grant, burst_cnt<=1.
- IDLE, transfer, MAX_BURST=1: stay IDLE, last_grant<=grant.
- LOCKED, transfer, burst_cnt+1 < MAX_BURST: stay LOCKED, burst_cnt+=1.
- LOCKED, transfer, burst_cnt+1 == MAX_BURST: go IDLE, last_grant<=owner, burst_cnt<=0.
- LOCKED, ~out_stall, valid_i[owner]=0: release on that edge (IDLE, last_grant<=owner, burst_cnt<=0).
  - In that same cycle the grant goes round-robin to another valid requester, if any; that transfer is processed as from IDLE.
- LOCKED during out_stall: lock held, counter frozen.

Flush:
- Highest priority after reset.
- Next edge: valid_o<=0, state IDLE, burst_cnt<=0, last_grant<=N-1.
- ready_o is all 0 during the flush cycle, so no requester beat is consumed.
- out and out_id hold their values.

Simultaneous events:
- Reset overrides flush; flush overrides transfer.
- A downstream accept (ready_i & valid_o) and a new load happen in the same cycle → back-to-back beats with no bubble.

Wrap-around:
- The search index wraps modulo N, valid for non-power-of-two N.
- The burst counter never exceeds MAX_BURST.

Protocol rules:
- Requesters must hold valid_i and in stable until accepted.
- The block never drops or duplicates a beat.
- Reset mid-burst discards the lock and the in-flight output beat.

Test Plan:
- N=4, MAX_BURST=1, all valid_i=1, ready_i=1 for 8 cycles → out_id sequence 0,1,2,3,0,1,2,3; valid_o=1 from cycle 1 onward; ready_o exactly one-hot each cycle.
- N=4, MAX_BURST=3, valid_i=4'b0101 continuous, ready_i=1 → out_id 0,0,0,2,2,2,0,…; requester 2 then requester 0 released only after 3 beats.
- MAX_BURST=3, requester 1 drops valid after 1 beat while requester 3 is valid → next beat is from 3 with no idle cycle; lock is released.
- ready_i=0 for 5 cycles with out=0xA5, out_id=2 loaded → valid_o, out, out_id stable; all ready_o=0; burst_cnt frozen; on ready_i=1 the next beat follows on the following edge.
- Mid-burst flush (cnt=2) with valid_o=1 → next cycle valid_o=0 and ready_o=0 in the flush cycle; the cycle after that, requester 0 wins (pointer reset).
- rst_core asserted mid-stream for 1 cycle → all outputs at reset values next edge; first grant after release goes to lowest-index valid requester.

Source files
------------

// File: rtl/hs_rr_arbiter.sv
// N:1 valid/ready round-robin arbiter with optional burst lock; one registered stage, 1-cycle latency, full throughput.
// Backpressure: an unaccepted output beat drops every ready_o and freezes the arbitration state.
module hs_rr_arbiter #(
  parameter int WIDTH = 1,
  parameter int N = 2,
  parameter int MAX_BURST = 1,
  localparam int IdBits = ($clog2(N) > 1) ? $clog2(N) : 1,
  localparam int CntBits = ($clog2(MAX_BURST + 1) > 1) ? $clog2(MAX_BURST + 1) : 1
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    flush,
  input  logic [N-1:0]            valid_i,
  output logic [N-1:0]            ready_o,
  input  logic [N-1:0][WIDTH-1:0] in,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic [WIDTH-1:0]        out,
  output logic [IdBits-1:0]       out_id
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [IdBits-1:0]  owner, owner_nxt;
  logic [IdBits-1:0]  last_grant, last_nxt;
  logic [IdBits-1:0]  base, cand, grant;
  logic [CntBits-1:0] burst_cnt, cnt_nxt;
  logic               out_stall, grant_vld, lock_hit, from_idle;

  assign out_stall = valid_o & ~ready_i;
  assign lock_hit  = (state == LOCKED) && valid_i[owner];
  // A released lock behaves as idle in the same cycle, so the search resumes after the owner.
  assign from_idle = !lock_hit;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    base      = (state == LOCKED) ? owner : last_grant;
    if (!out_stall) begin
      if (lock_hit) begin
        grant_vld = 1'b1;
        grant     = owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          cand = IdBits'((int'(base) + k) % N);
          if (!grant_vld && valid_i[cand]) begin
            grant_vld = 1'b1;
            grant     = cand;
          end
        end
      end
    end
  end

  always_comb begin
    ready_o = '0;
    if (!rst_core && !flush && grant_vld) ready_o[grant] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = burst_cnt;
    last_nxt  = last_grant;
    if (!out_stall) begin
      if (state == LOCKED && !valid_i[owner]) begin
        state_nxt = IDLE;
        last_nxt  = owner;
        cnt_nxt   = '0;
      end
      if (grant_vld) begin
        if (from_idle) begin
          if (MAX_BURST > 1) begin
            state_nxt = LOCKED;
            owner_nxt = grant;
            cnt_nxt   = CntBits'(1);
          end else begin
            last_nxt = grant;
          end
        end else if (int'(burst_cnt) + 1 < MAX_BURST) begin
          cnt_nxt = burst_cnt + CntBits'(1);
        end else begin
          state_nxt = IDLE;
          last_nxt  = owner;
          cnt_nxt   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IdBits'(N - 1);
      burst_cnt  <= '0;
      valid_o    <= 1'b0;
      out        <= '0;
      out_id     <= '0;
    end else if (flush) begin
      state      <= IDLE;
      last_grant <= IdBits'(N - 1);
      burst_cnt  <= '0;
      valid_o    <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_nxt;
      burst_cnt  <= cnt_nxt;
      if (!out_stall) begin
        valid_o <= grant_vld;
        if (grant_vld) begin
          out    <= in[grant];
          out_id <= grant;
        end
      end
    end
  end

endmodule
